// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates the single write port
// between the pipeline writeback stage and the long-latency unit. It also
// keeps a busy scoreboard of pending long-latency destinations and stalls
// issue on RAW/WAW hazards against them.
module regfile_wb_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  input  logic        i_lu_valid,
  input  logic [4:0]  i_lu_rd,
  input  logic [31:0] i_lu_data,
  output logic        o_lu_ready,
  input  logic        i_issue_valid,
  input  logic        i_issue_long,
  input  logic [4:0]  i_issue_rs1,
  input  logic [4:0]  i_issue_rs2,
  input  logic [4:0]  i_issue_rd,
  output logic        o_issue_stall,
  output logic        o_reg_write,
  output logic [4:0]  o_rd,
  output logic [31:0] o_write_data,
  output logic [31:0] o_busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             force_lu;
  logic             wb_grant;
  logic             lu_hs;
  logic             grant_any;
  logic [RW-1:0]    win_rd;
  logic [XLEN-1:0]  win_data;
  logic             issue_set;
  logic [XLEN-1:0]  busy_next;

  // Port arbitration: WB wins unless the LU has waited long enough to force.
  always_comb begin
    o_wb_stall = force_lu;
    o_lu_ready = force_lu ? i_lu_valid : (i_lu_valid & ~i_wb_valid);
    wb_grant   = i_wb_valid & ~force_lu;
    lu_hs      = i_lu_valid & o_lu_ready;
    grant_any  = wb_grant | lu_hs;
    win_rd     = lu_hs ? i_lu_rd : i_wb_rd;
    win_data   = lu_hs ? i_lu_data : i_wb_data;
  end

  // Starvation counter: saturating count of cycles the LU waited unserved.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (lu_hs) begin
      wait_cnt_next = '0;
    end else if (i_lu_valid && (wait_cnt != CNT_MAX)) begin
      wait_cnt_next = wait_cnt + CNT_W'(1);
    end
  end

  // Hazard detection against pending long-latency destinations.
  always_comb begin
    o_issue_stall = i_issue_valid &
                    (o_busy[i_issue_rs1] | o_busy[i_issue_rs2] | o_busy[i_issue_rd]);
    issue_set     = i_issue_valid & i_issue_long & ~o_issue_stall &
                    (i_issue_rd != RW'(0));
  end

  // Scoreboard update: LU handshake clears, long issue sets; set wins.
  always_comb begin
    busy_next = o_busy;
    if (lu_hs) begin
      busy_next[i_lu_rd] = 1'b0;
    end
    if (issue_set) begin
      busy_next[i_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Counter, force flag and scoreboard state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt <= '0;
      force_lu <= 1'b0;
      o_busy   <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
      force_lu <= (wait_cnt_next >= LIMIT);
      o_busy   <= busy_next;
    end
  end

  // Registered write port; rd=0 grants complete but never write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_reg_write  <= 1'b0;
      o_rd         <= '0;
      o_write_data <= '0;
    end else begin
      o_reg_write <= grant_any & (win_rd != RW'(0));
      if (grant_any) begin
        o_rd         <= win_rd;
        o_write_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;

  logic        i_clk;
  logic        i_reset;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_wb_stall;
  logic        i_lu_valid;
  logic [4:0]  i_lu_rd;
  logic [31:0] i_lu_data;
  logic        o_lu_ready;
  logic        i_issue_valid;
  logic        i_issue_long;
  logic [4:0]  i_issue_rs1;
  logic [4:0]  i_issue_rs2;
  logic [4:0]  i_issue_rd;
  logic        o_issue_stall;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic [31:0] o_write_data;
  logic [31:0] o_busy;

  int vectors;
  int miscompares;
  int proto_errs;

  regfile_wb_scheduler #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_wb_stall(o_wb_stall),
    .i_lu_valid(i_lu_valid), .i_lu_rd(i_lu_rd), .i_lu_data(i_lu_data),
    .o_lu_ready(o_lu_ready),
    .i_issue_valid(i_issue_valid), .i_issue_long(i_issue_long),
    .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2), .i_issue_rd(i_issue_rd),
    .o_issue_stall(o_issue_stall),
    .o_reg_write(o_reg_write), .o_rd(o_rd), .o_write_data(o_write_data),
    .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // LU handshake to a destination that is not busy is a protocol error.
  always @(negedge i_clk) begin
    if (!i_reset && i_lu_valid && o_lu_ready) begin
      assert (o_busy[i_lu_rd] === 1'b1) else begin
        proto_errs++;
        $info("protocol violation: LU handshake to non-busy x%0d", i_lu_rd);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; proto_errs = 0;
    i_reset = 1'b1;
    i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    i_lu_valid = 1'b0; i_lu_rd = '0; i_lu_data = '0;
    i_issue_valid = 1'b0; i_issue_long = 1'b0;
    i_issue_rs1 = '0; i_issue_rs2 = '0; i_issue_rd = '0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_reg_write", 32'(o_reg_write), 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_data", o_write_data, 32'd0);
    chk("rst_busy", o_busy, 32'd0);
    i_reset = 1'b0;
    tick();
    chk("post_rst_reg_write", 32'(o_reg_write), 32'd0);
    chk("post_rst_stall", 32'(o_wb_stall), 32'd0);

    // Lone WB write, then rd=0 write suppressed
    i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'hDEAD_BEEF;
    #1 chk("lone_wb_stall", 32'(o_wb_stall), 32'd0);
    tick();
    chk("lone_wb_we", 32'(o_reg_write), 32'd1);
    chk("lone_wb_rd", 32'(o_rd), 32'd5);
    chk("lone_wb_data", o_write_data, 32'hDEAD_BEEF);
    i_wb_rd = 5'd0; i_wb_data = 32'h1111_1111;
    tick();
    chk("wb_rd0_we", 32'(o_reg_write), 32'd0);
    i_wb_valid = 1'b0;
    tick();
    chk("idle_we", 32'(o_reg_write), 32'd0);

    // Scoreboard RAW
    i_issue_valid = 1'b1; i_issue_long = 1'b1; i_issue_rd = 5'd9;
    #1 chk("long9_stall", 32'(o_issue_stall), 32'd0);
    tick();
    chk("long9_busy", o_busy, 32'h0000_0200);
    i_issue_long = 1'b0; i_issue_rs1 = 5'd9; i_issue_rd = 5'd3;
    #1 chk("raw9_stall_a", 32'(o_issue_stall), 32'd1);
    tick();
    chk("raw9_busy_hold", o_busy, 32'h0000_0200);
    chk("raw9_stall_b", 32'(o_issue_stall), 32'd1);
    i_lu_valid = 1'b1; i_lu_rd = 5'd9; i_lu_data = 32'hCAFE_0009;
    #1 chk("lu9_ready", 32'(o_lu_ready), 32'd1);
    chk("raw9_stall_clr_cycle", 32'(o_issue_stall), 32'd1);
    tick();
    i_lu_valid = 1'b0;
    chk("lu9_busy_clr", o_busy, 32'd0);
    chk("lu9_we", 32'(o_reg_write), 32'd1);
    chk("lu9_rd", 32'(o_rd), 32'd9);
    chk("lu9_data", o_write_data, 32'hCAFE_0009);
    #1 chk("raw9_stall_released", 32'(o_issue_stall), 32'd0);
    i_issue_valid = 1'b0; i_issue_rs1 = '0;

    // Simultaneous clear and set of rd=9: set wins (flagged as protocol error)
    i_lu_valid = 1'b1; i_lu_rd = 5'd9; i_lu_data = 32'h0000_0099;
    i_issue_valid = 1'b1; i_issue_long = 1'b1; i_issue_rd = 5'd9;
    #1 chk("sim_stall", 32'(o_issue_stall), 32'd0);
    chk("sim_ready", 32'(o_lu_ready), 32'd1);
    tick();
    chk("sim_busy_set_wins", o_busy, 32'h0000_0200);
    chk("sim_proto_flag", 32'(proto_errs), 32'd1);
    chk("sim_rd", 32'(o_rd), 32'd9);
    i_issue_valid = 1'b0; i_lu_data = 32'h0000_0098;
    tick();
    i_lu_valid = 1'b0;
    chk("sim_busy_clr", o_busy, 32'd0);
    chk("sim_proto_clean", 32'(proto_errs), 32'd1);
    i_issue_valid = 1'b1; i_issue_long = 1'b1; i_issue_rd = 5'd0;
    #1 chk("long0_stall", 32'(o_issue_stall), 32'd0);
    tick();
    chk("long0_busy", o_busy, 32'd0);

    // Contention: LU forced in after four waiting cycles
    i_issue_rd = 5'd7;
    tick();
    chk("long7_busy", o_busy, 32'h0000_0080);
    i_issue_valid = 1'b0; i_issue_long = 1'b0; i_issue_rd = '0;
    i_wb_valid = 1'b1; i_wb_rd = 5'd1;
    i_lu_valid = 1'b1; i_lu_rd = 5'd7; i_lu_data = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      i_wb_data = 32'(32'hA0 + c);
      #1;
      chk("cont_lu_ready", 32'(o_lu_ready), 32'd0);
      chk("cont_wb_stall", 32'(o_wb_stall), 32'd0);
      tick();
      chk("cont_wb_rd", 32'(o_rd), 32'd1);
      chk("cont_wb_data", o_write_data, 32'(32'hA0 + c));
    end
    i_wb_data = 32'h0000_00A4;
    #1 chk("force_wb_stall", 32'(o_wb_stall), 32'd1);
    chk("force_lu_ready", 32'(o_lu_ready), 32'd1);
    tick();
    chk("force_rd", 32'(o_rd), 32'd7);
    chk("force_data", o_write_data, 32'h1234_5678);
    chk("force_busy", o_busy, 32'd0);
    i_lu_valid = 1'b0;
    #1 chk("after_force_stall", 32'(o_wb_stall), 32'd0);
    tick();
    chk("after_force_rd", 32'(o_rd), 32'd1);
    chk("after_force_data", o_write_data, 32'h0000_00A4);

    // Idle LU with active WB: never stalls
    for (int i = 0; i < 20; i++) begin
      i_wb_rd = 5'((i % 31) + 1);
      i_wb_data = 32'(i * 3 + 256);
      #1 chk("idle_lu_stall", 32'(o_wb_stall), 32'd0);
      tick();
      chk("idle_lu_we", 32'(o_reg_write), 32'd1);
      chk("idle_lu_rd", 32'(o_rd), 32'((i % 31) + 1));
    end
    i_wb_valid = 1'b0;

    // Asynchronous reset mid-operation
    i_issue_valid = 1'b1; i_issue_long = 1'b1; i_issue_rd = 5'd5;
    tick();
    chk("pre_rst_busy", o_busy, 32'h0000_0020);
    i_issue_valid = 1'b0; i_issue_long = 1'b0; i_issue_rd = '0;
    i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h55AA_55AA;
    tick();
    chk("pre_rst_we", 32'(o_reg_write), 32'd1);
    #2;
    i_reset = 1'b1;
    i_wb_valid = 1'b0;
    #1;
    chk("async_rst_we", 32'(o_reg_write), 32'd0);
    chk("async_rst_rd", 32'(o_rd), 32'd0);
    chk("async_rst_data", o_write_data, 32'd0);
    chk("async_rst_busy", o_busy, 32'd0);
    tick();
    i_reset = 1'b0;
    tick();
    chk("post_async_we", 32'(o_reg_write), 32'd0);
    chk("post_async_busy", o_busy, 32'd0);
    chk("post_async_stall", 32'(o_wb_stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
